// File: rtl/pmem_arbiter.sv
// pmem_arbiter: registered round-robin arbiter between i-cache and d-cache
// for the single cacheline adaptor; a grant is held until the adaptor responds.
module pmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int RR_EN  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_pmem_read,
   input  logic              i_pmem_write,
   input  logic [ADDR_W-1:0] i_pmem_address,
   input  logic [LINE_W-1:0] i_pmem_wdata,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              ab_pmem_read,
   output logic              ab_pmem_write,
   output logic [ADDR_W-1:0] ab_pmem_address,
   output logic [LINE_W-1:0] ab_pmem_wdata,
   input  logic [LINE_W-1:0] ab_pmem_rdata,
   input  logic              ab_pmem_resp
);
   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
   state_t state, state_n;
   logic last_d, last_d_n, rd_n, wr_n, req_i, req_d, pick_d;
   logic [ADDR_W-1:0] addr_n;
   logic [LINE_W-1:0] wdata_n;
   assign req_i  = i_pmem_read | i_pmem_write;
   assign req_d  = d_pmem_read | d_pmem_write;
   // d wins when alone, under fixed priority, or when i was served last
   assign pick_d = req_d & (~req_i | (RR_EN == 0) | ~last_d);
   always_comb begin
      state_n  = state;
      last_d_n = last_d;
      rd_n     = ab_pmem_read;
      wr_n     = ab_pmem_write;
      addr_n   = ab_pmem_address;
      wdata_n  = ab_pmem_wdata;
      if (state == IDLE && (req_i || req_d)) begin
         state_n  = pick_d ? GNT_D : GNT_I;
         last_d_n = pick_d;
         wr_n     = pick_d ? d_pmem_write : i_pmem_write;
         rd_n     = pick_d ? d_pmem_read & ~d_pmem_write : i_pmem_read & ~i_pmem_write;
         addr_n   = pick_d ? d_pmem_address : i_pmem_address;
         wdata_n  = pick_d ? d_pmem_wdata : i_pmem_wdata;
      end else if (state != IDLE && ab_pmem_resp) begin
         state_n = IDLE;
         rd_n    = 1'b0;
         wr_n    = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         last_d          <= 1'b1;
         ab_pmem_read    <= 1'b0;
         ab_pmem_write   <= 1'b0;
         ab_pmem_address <= '0;
         ab_pmem_wdata   <= '0;
      end else begin
         state           <= state_n;
         last_d          <= last_d_n;
         ab_pmem_read    <= rd_n;
         ab_pmem_write   <= wr_n;
         ab_pmem_address <= addr_n;
         ab_pmem_wdata   <= wdata_n;
      end
   end
   assign i_pmem_resp  = (state == GNT_I) && ab_pmem_resp;
   assign d_pmem_resp  = (state == GNT_D) && ab_pmem_resp;
   assign i_pmem_rdata = i_pmem_resp ? ab_pmem_rdata : '0;
   assign d_pmem_rdata = d_pmem_resp ? ab_pmem_rdata : '0;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed vectors for pmem_arbiter; dut1 is round-robin,
// dut0 is fixed priority; each has its own adaptor response strobe.
module tb_pmem_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;
   logic clk = 1'b0, reset = 1'b1;
   logic i_read = 0, i_write = 0, d_read = 0, d_write = 0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [LW-1:0] i_wdata = '0, d_wdata = '0, ab_rdata = '0;
   logic ab_resp0 = 0, ab_resp1 = 0;
   logic [LW-1:0] i_rdata0, d_rdata0, ab_wdata0, i_rdata1, d_rdata1, ab_wdata1;
   logic i_resp0, d_resp0, ab_read0, ab_write0, i_resp1, d_resp1, ab_read1, ab_write1;
   logic [AW-1:0] ab_addr0, ab_addr1;
   int n_vec = 0, n_bad = 0, cnt_i, cnt_d;
   bit rr_seq [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
   bit fx_seq [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

   always #5 clk = ~clk;

   pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(1)) dut1 (
      .clk(clk), .reset(reset),
      .i_pmem_read(i_read), .i_pmem_write(i_write), .i_pmem_address(i_addr),
      .i_pmem_wdata(i_wdata), .i_pmem_rdata(i_rdata1), .i_pmem_resp(i_resp1),
      .d_pmem_read(d_read), .d_pmem_write(d_write), .d_pmem_address(d_addr),
      .d_pmem_wdata(d_wdata), .d_pmem_rdata(d_rdata1), .d_pmem_resp(d_resp1),
      .ab_pmem_read(ab_read1), .ab_pmem_write(ab_write1), .ab_pmem_address(ab_addr1),
      .ab_pmem_wdata(ab_wdata1), .ab_pmem_rdata(ab_rdata), .ab_pmem_resp(ab_resp1));

   pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(0)) dut0 (
      .clk(clk), .reset(reset),
      .i_pmem_read(i_read), .i_pmem_write(i_write), .i_pmem_address(i_addr),
      .i_pmem_wdata(i_wdata), .i_pmem_rdata(i_rdata0), .i_pmem_resp(i_resp0),
      .d_pmem_read(d_read), .d_pmem_write(d_write), .d_pmem_address(d_addr),
      .d_pmem_wdata(d_wdata), .d_pmem_rdata(d_rdata0), .d_pmem_resp(d_resp0),
      .ab_pmem_read(ab_read0), .ab_pmem_write(ab_write0), .ab_pmem_address(ab_addr0),
      .ab_pmem_wdata(ab_wdata0), .ab_pmem_rdata(ab_rdata), .ab_pmem_resp(ab_resp0));

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   // checks the live grant, pulses the adaptor response, then checks the bubble
   task automatic serve(input bit use0, input bit exp_d, input logic [AW-1:0] exp_addr,
                        input logic [LW-1:0] line, input string tag);
      chk({tag, "_addr"}, use0 ? ab_addr0 : ab_addr1, exp_addr);
      chk({tag, "_req"}, use0 ? (ab_read0 | ab_write0) : (ab_read1 | ab_write1), 1);
      ab_rdata = line;
      if (use0) ab_resp0 = 1'b1; else ab_resp1 = 1'b1;
      #1;
      chk({tag, "_iresp"}, use0 ? i_resp0 : i_resp1, !exp_d);
      chk({tag, "_dresp"}, use0 ? d_resp0 : d_resp1, exp_d);
      chk({tag, "_rdata"}, exp_d ? (use0 ? d_rdata0 : d_rdata1) : (use0 ? i_rdata0 : i_rdata1), line);
      chk({tag, "_other_rdata"}, exp_d ? (use0 ? i_rdata0 : i_rdata1) : (use0 ? d_rdata0 : d_rdata1), 0);
      tick();
      ab_resp0 = 1'b0;
      ab_resp1 = 1'b0;
      ab_rdata = '0;
      #1;
      chk({tag, "_resp_gone"}, use0 ? (i_resp0 | d_resp0) : (i_resp1 | d_resp1), 0);
      chk({tag, "_bubble"}, use0 ? (ab_read0 | ab_write0) : (ab_read1 | ab_write1), 0);
   endtask

   initial begin
      do_reset();
      chk("rst_read", ab_read1, 0);
      chk("rst_write", ab_write1, 0);
      chk("rst_addr", ab_addr1, 0);
      chk("rst_wdata", ab_wdata1, 0);
      chk("rst_resp", {i_resp1, d_resp1, i_resp0, d_resp0}, 0);
      chk("rst_rdata", i_rdata1 | d_rdata1, 0);

      i_read = 1'b1;
      i_addr = 32'h0000_0060;
      tick();
      chk("t1_read_next", ab_read1, 1);
      chk("t1_write_next", ab_write1, 0);
      repeat (7) tick();
      chk("t1_held", {ab_read1, i_resp1, d_resp1}, 3'b100);
      serve(0, 0, 32'h60, {32{8'hA5}}, "t1");
      i_read = 1'b0;

      do_reset();
      i_read = 1'b1; i_addr = 32'h100;
      d_read = 1'b1; d_addr = 32'h200;
      tick();
      serve(0, 0, 32'h100, {8{32'h1111_0100}}, "t2_i");
      i_read = 1'b0;
      tick();
      serve(0, 1, 32'h200, {8{32'h2222_0200}}, "t2_d");
      d_read = 1'b0;

      d_write = 1'b1; d_addr = 32'h300; d_wdata = {8{32'hDEAD_BEEF}};
      tick();
      chk("t3_write", ab_write1, 1);
      chk("t3_read", ab_read1, 0);
      d_addr = 32'h400; d_wdata = '1;
      repeat (3) tick();
      chk("t3_addr_held", ab_addr1, 32'h300);
      chk("t3_wdata_held", ab_wdata1, {8{32'hDEAD_BEEF}});
      chk("t3_write_held", ab_write1, 1);
      serve(0, 1, 32'h300, '0, "t3");
      d_write = 1'b0;

      i_read = 1'b1; i_write = 1'b1; i_addr = 32'h500;
      tick();
      chk("rw_write_wins", ab_write1, 1);
      chk("rw_read_clear", ab_read1, 0);
      i_read = 1'b0; i_write = 1'b0;
      tick();
      serve(0, 0, 32'h500, {4{64'h0123_4567_89AB_CDEF}}, "drop");

      do_reset();
      cnt_i = 0; cnt_d = 0;
      i_read = 1'b1; i_addr = 32'h1000;
      d_read = 1'b1; d_addr = 32'h2000;
      tick();
      for (int k = 0; k < 8; k++) begin
         serve(0, rr_seq[k], rr_seq[k] ? 32'h2000 : 32'h1000, {8{k[31:0]}}, "rr");
         if (rr_seq[k]) cnt_d++; else cnt_i++;
         if (cnt_i == 4) i_read = 1'b0;
         if (cnt_d == 4) d_read = 1'b0;
         tick();
      end

      do_reset();
      cnt_i = 0; cnt_d = 0;
      i_read = 1'b1; i_addr = 32'h1000;
      d_read = 1'b1; d_addr = 32'h2000;
      tick();
      for (int k = 0; k < 8; k++) begin
         serve(1, fx_seq[k], fx_seq[k] ? 32'h2000 : 32'h1000, {8{~k[31:0]}}, "fix");
         if (fx_seq[k]) cnt_d++; else cnt_i++;
         if (cnt_i == 4) i_read = 1'b0;
         if (cnt_d == 4) d_read = 1'b0;
         tick();
      end

      do_reset();
      d_read = 1'b1; d_addr = 32'h700;
      tick();
      chk("t5_granted", {ab_read1, ab_addr1}, {1'b1, 32'h700});
      tick();
      reset = 1'b1;
      d_read = 1'b0;
      #1;
      chk("t5_async_clear", {ab_read1, ab_write1, ab_addr1}, 0);
      chk("t5_no_resp", {i_resp1, d_resp1}, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("t5_idle", {ab_read1, ab_write1}, 0);

      ab_resp1 = 1'b1; ab_resp0 = 1'b1; ab_rdata = {32{8'h5A}};
      #1;
      chk("t6_resp1", {i_resp1, d_resp1}, 0);
      chk("t6_resp0", {i_resp0, d_resp0}, 0);
      chk("t6_rdata", i_rdata1 | d_rdata1, 0);
      tick();
      ab_resp1 = 1'b0; ab_resp0 = 1'b0; ab_rdata = '0;
      tick();
      chk("t6_still_idle", {ab_read1, ab_write1}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
